ad9634_cfg_sequencer: RTL and testbench

Register-access sequencer directly upstream of the AD9634 SPI shifter (`spi_fsm`). It accepts single-register read/write commands over a valid/ready handshake and formats each into the 24-bit AD9634 SPI word. It drives the shifter's `load`/`data_in`, tracks transaction completion via `spi_cs_n`, and returns read data or an error. On writes it optionally issues the AD9634 transfer-update write (0x0FF = 0x01).

---
 rtl/ad9634_spi_pkg.sv | 37 +++
 rtl/spi_timeout_ctr.sv | 31 +++
 rtl/ad9634_cfg_sequencer.sv | 156 +++++++++++++++
 tb/tb_ad9634_cfg_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9634_spi_pkg.sv
// rtl/ad9634_spi_pkg.sv - AD9634 SPI word layout, sequencer states and word builder
package ad9634_spi_pkg;

  // Field positions inside the 24-bit AD9634 instruction+data word
  localparam int RW_BIT   = 23;
  localparam int W_MSB    = 22;
  localparam int W_LSB    = 21;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Transfer-update register: writing 0x01 here commits shadowed settings
  localparam logic [12:0] REG_TRANSFER = 13'h0FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_SETTLE,
    ST_RESP
  } seq_state_t;

  // Single-byte transfer word; reads carry a zero data byte
  function automatic logic [23:0] build_word(input logic rw, input logic [12:0] addr,
                                             input logic [7:0] data);
    logic [23:0] w;
    w                    = '0;
    w[RW_BIT]            = rw;
    w[W_MSB:W_LSB]       = 2'b00;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[DATA_MSB:DATA_LSB] = rw ? 8'h00 : data;
    return w;
  endfunction

endpackage

// File: rtl/spi_timeout_ctr.sv
// rtl/spi_timeout_ctr.sv - 16-bit saturating transfer watchdog counter
module spi_timeout_ctr #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic hit_next
);

  localparam logic [16:0] LIMIT_W = 17'(LIMIT);

  logic [15:0] count;

  // Count enabled cycles, holding at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // hit_next flags the cycle whose increment lands on LIMIT, so the caller
  // can leave its wait state exactly LIMIT cycles after the count started
  assign expired  = {1'b0, count} >= LIMIT_W;
  assign hit_next = ({1'b0, count} + 17'd1) >= LIMIT_W;

endmodule

// File: rtl/ad9634_cfg_sequencer.sv
// rtl/ad9634_cfg_sequencer.sv - AD9634 register read/write sequencer in front of spi_fsm
module ad9634_cfg_sequencer
  import ad9634_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          AUTO_UPDATE    = 1'b1,
  parameter logic [12:0] UPDATE_ADDR    = REG_TRANSFER,
  parameter logic [7:0]  UPDATE_DATA    = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_load,
  output logic [23:0] spi_word,
  input  logic        spi_cs_n,
  input  logic [23:0] spi_rdata
);

  seq_state_t state, state_next;

  logic rw_q;
  logic upd_q;
  logic err_q;
  logic settle_q;
  logic accept;
  logic go_update;
  logic timeout_hit;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;
  logic tmo_hit_next;
  logic tmo;
  logic unused_rdata_hi;

  // Only the low data byte of the shifter's capture register is meaningful
  assign unused_rdata_hi = ^spi_rdata[23:8];

  spi_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired),
    .hit_next(tmo_hit_next)
  );

  assign tmo    = tmo_hit_next || tmo_expired;
  assign accept = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    spi_load    = 1'b0;
    rsp_valid   = 1'b0;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    go_update   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        spi_load   = 1'b1;
        tmo_clr    = 1'b1;
        state_next = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        tmo_en = 1'b1;
        if (tmo) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESP;
        end else if (!spi_cs_n) begin
          state_next = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        tmo_en = 1'b1;
        if (tmo) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESP;
        end else if (spi_cs_n) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q) begin
          if (AUTO_UPDATE && !rw_q && !upd_q) begin
            go_update  = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, update/error/settle flags and the word held for the shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q     <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= 1'b0;
      spi_word <= '0;
    end else begin
      settle_q <= (state == ST_SETTLE) && !settle_q;
      if (accept) begin
        rw_q     <= cmd_rw;
        upd_q    <= 1'b0;
        err_q    <= 1'b0;
        spi_word <= build_word(cmd_rw, cmd_addr, cmd_wdata);
      end
      if (go_update) begin
        upd_q    <= 1'b1;
        spi_word <= build_word(1'b0, UPDATE_ADDR, UPDATE_DATA);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_err   = (state == ST_RESP) && err_q;
  assign rsp_rdata = ((state == ST_RESP) && rw_q && !err_q) ? spi_rdata[7:0] : 8'h00;

endmodule

// File: tb/tb_ad9634_cfg_sequencer.sv
// tb/tb_ad9634_cfg_sequencer.sv - directed vector bench for ad9634_cfg_sequencer
module tb_ad9634_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        cmd_valid;
  logic [1:0]        cmd_ready;
  logic              cmd_rw;
  logic [12:0]       cmd_addr;
  logic [7:0]        cmd_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0][7:0]   rsp_rdata;
  logic [1:0]        rsp_err;
  logic [1:0]        busy;
  logic [1:0]        spi_load;
  logic [1:0][23:0]  spi_word;
  logic [1:0]        spi_cs_n;
  logic [1:0][23:0]  spi_rdata;
  logic [1:0]        stuck;

  // dut0: auto-update on; dut1: auto-update off; both with a short watchdog
  ad9634_cfg_sequencer #(.TIMEOUT_CYCLES(32), .AUTO_UPDATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .spi_load(spi_load[0]), .spi_word(spi_word[0]),
    .spi_cs_n(spi_cs_n[0]), .spi_rdata(spi_rdata[0])
  );

  ad9634_cfg_sequencer #(.TIMEOUT_CYCLES(32), .AUTO_UPDATE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .spi_load(spi_load[1]), .spi_word(spi_word[1]),
    .spi_cs_n(spi_cs_n[1]), .spi_rdata(spi_rdata[1])
  );

  // Behavioural shifter: cs_n low for 16 cycles after a load; reads of 0x001 return 0x0C
  logic [1:0]       m_busy;
  logic [1:0][4:0]  m_cnt;
  logic [1:0][23:0] m_word;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]    <= 1'b0;
        m_cnt[i]     <= '0;
        spi_rdata[i] <= '0;
      end else if (spi_load[i] && !stuck[i]) begin
        m_busy[i] <= 1'b1;
        m_cnt[i]  <= '0;
        m_word[i] <= spi_word[i];
      end else if (m_busy[i]) begin
        m_cnt[i] <= m_cnt[i] + 5'd1;
        if (m_cnt[i] == 5'd15) begin
          m_busy[i]    <= 1'b0;
          spi_rdata[i] <= {16'h0, (m_word[i][23] && m_word[i][20:8] == 13'h001) ? 8'h0C : 8'h00};
        end
      end
    end
  end
  assign spi_cs_n = ~m_busy;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge
  int n_rsp [2];
  int n_acc [2];
  int rsp_cyc [2];
  int acc_cyc [2];
  int csh_cyc [2];
  logic [7:0] r_rdata [2];
  logic       r_err [2];
  logic [1:0] rdy_q = 2'b00;
  logic [1:0] cs_q = 2'b11;
  logic [23:0] ldq0[$];
  logic [23:0] ldq1[$];
  int ldc0[$];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cmd_valid[i] && rdy_q[i]) begin
        n_acc[i]   <= n_acc[i] + 1;
        acc_cyc[i] <= cyc - 1;
      end
      rdy_q[i] <= cmd_ready[i];
      if (spi_cs_n[i] && !cs_q[i]) csh_cyc[i] <= cyc;
      cs_q[i] <= spi_cs_n[i];
      if (rsp_valid[i]) begin
        n_rsp[i]   <= n_rsp[i] + 1;
        rsp_cyc[i] <= cyc;
        r_rdata[i] <= rsp_rdata[i];
        r_err[i]   <= rsp_err[i];
      end
    end
    if (spi_load[0]) begin
      ldq0.push_back(spi_word[0]);
      ldc0.push_back(cyc);
    end
    if (spi_load[1]) ldq1.push_back(spi_word[1]);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic rw, input logic [12:0] a, input logic [7:0] d);
    int a0;
    a0 = n_acc[i];
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid[i] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (n_acc[i] > a0) break;
    end
    cmd_valid[i] = 1'b0;
    chk("accepted", 32'(n_acc[i] > a0), 32'd1);
  endtask

  task automatic wait_rsp(input int i, input int start);
    for (int k = 0; k < 300; k++) begin
      if (n_rsp[i] > start) break;
      tick(1);
    end
    chk("rsp_arrived", 32'(n_rsp[i] > start), 32'd1);
  endtask

  typedef struct {
    logic        rw;
    logic [12:0] addr;
    logic [7:0]  wdata;
    int          nload;
    logic [23:0] w0;
    logic [23:0] w1;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int a0;
    vecs[0] = '{1'b0, 13'h014,  8'hA5, 2, 24'h0014A5, 24'h00FF01, 8'h00};
    vecs[1] = '{1'b1, 13'h001,  8'h5A, 1, 24'h800100, 24'h000000, 8'h0C};
    vecs[2] = '{1'b0, 13'h1FFF, 8'hFF, 2, 24'h1FFFFF, 24'h00FF01, 8'h00};
    vecs[3] = '{1'b1, 13'h1ABC, 8'h00, 1, 24'h9ABC00, 24'h000000, 8'h00};

    rst = 1'b1; cmd_valid = 2'b00; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; stuck = 2'b00;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_spi_load", 32'(spi_load[0]), 32'd0);
    chk("rst_spi_word", 32'(spi_word[0]), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);

    // Table-driven single commands on the auto-update instance
    for (int v = 0; v < 4; v++) begin
      r0 = n_rsp[0];
      ldq0.delete(); ldc0.delete();
      send(0, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      wait_rsp(0, r0);
      tick(5);
      chk($sformatf("v%0d_nload", v), 32'(ldq0.size()), 32'(vecs[v].nload));
      if (ldq0.size() > 0) begin
        chk($sformatf("v%0d_word0", v), 32'(ldq0[0]), 32'(vecs[v].w0));
        chk($sformatf("v%0d_acc2load", v), 32'(ldc0[0] - acc_cyc[0]), 32'd1);
      end
      if (ldq0.size() > 1) chk($sformatf("v%0d_word1", v), 32'(ldq0[1]), 32'(vecs[v].w1));
      chk($sformatf("v%0d_nrsp", v), 32'(n_rsp[0] - r0), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(r_err[0]), 32'd0);
      chk($sformatf("v%0d_rdata", v), 32'(r_rdata[0]), 32'(vecs[v].rdata));
      chk($sformatf("v%0d_csh2rsp", v), 32'(rsp_cyc[0] - csh_cyc[0]), 32'd3);
      chk($sformatf("v%0d_ready", v), 32'(cmd_ready[0]), 32'd1);
    end

    // Auto-update disabled: a write of the transfer register loads once
    r0 = n_rsp[1];
    ldq1.delete();
    send(1, 1'b0, 13'h0FF, 8'h01);
    wait_rsp(1, r0);
    tick(5);
    chk("noupd_nload", 32'(ldq1.size()), 32'd1);
    if (ldq1.size() > 0) chk("noupd_word", 32'(ldq1[0]), 32'h00FF01);
    chk("noupd_nrsp", 32'(n_rsp[1] - r0), 32'd1);
    chk("noupd_err", 32'(r_err[1]), 32'd0);
    chk("noupd_csh2rsp", 32'(rsp_cyc[1] - csh_cyc[1]), 32'd3);

    // Shifter never drops cs_n: timeout 32 cycles after WAIT_LOW entry, update abandoned
    stuck[0] = 1'b1;
    r0 = n_rsp[0];
    ldq0.delete(); ldc0.delete();
    send(0, 1'b0, 13'h055, 8'h77);
    wait_rsp(0, r0);
    tick(5);
    chk("tmo_err", 32'(r_err[0]), 32'd1);
    chk("tmo_rdata", 32'(r_rdata[0]), 32'd0);
    chk("tmo_nload", 32'(ldq0.size()), 32'd1);
    if (ldc0.size() > 0) chk("tmo_latency", 32'(rsp_cyc[0] - ldc0[0]), 32'd33);
    chk("tmo_nrsp", 32'(n_rsp[0] - r0), 32'd1);
    chk("tmo_ready", 32'(cmd_ready[0]), 32'd1);
    stuck[0] = 1'b0;

    // cmd_valid held with changing payloads: second command accepted only after RESP
    r0 = n_rsp[0];
    a0 = n_acc[0];
    ldq0.delete(); ldc0.delete();
    cmd_rw = 1'b0; cmd_addr = 13'h020; cmd_wdata = 8'h11; cmd_valid[0] = 1'b1;
    tick(1);
    cmd_addr = 13'h040; cmd_wdata = 8'h33;
    tick(3);
    cmd_addr = 13'h030; cmd_wdata = 8'h22;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      if (n_acc[0] >= a0 + 2) break;
    end
    cmd_valid[0] = 1'b0;
    chk("hold_nacc", 32'(n_acc[0] - a0), 32'd2);
    chk("hold_nrsp_at_acc", 32'(n_rsp[0] - r0), 32'd1);
    chk("hold_acc_after_rsp", 32'(acc_cyc[0] - rsp_cyc[0]), 32'd1);
    wait_rsp(0, r0 + 1);
    tick(5);
    chk("hold_nload", 32'(ldq0.size()), 32'd4);
    if (ldq0.size() == 4) begin
      chk("hold_w0", 32'(ldq0[0]), 32'h002011);
      chk("hold_w1", 32'(ldq0[1]), 32'h00FF01);
      chk("hold_w2", 32'(ldq0[2]), 32'h003022);
      chk("hold_w3", 32'(ldq0[3]), 32'h00FF01);
    end
    chk("hold_nrsp", 32'(n_rsp[0] - r0), 32'd2);

    // Reset during WAIT_HIGH aborts silently, then a fresh read completes
    r0 = n_rsp[0];
    ldq0.delete(); ldc0.delete();
    send(0, 1'b1, 13'h001, 8'h00);
    for (int k = 0; k < 50; k++) begin
      if (!spi_cs_n[0]) break;
      tick(1);
    end
    chk("rstmid_cs_low", 32'(spi_cs_n[0]), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rstmid_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_load", 32'(spi_load[0]), 32'd0);
    chk("rstmid_word", 32'(spi_word[0]), 32'h0);
    chk("rstmid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rstmid_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("rstmid_err", 32'(rsp_err[0]), 32'd0);
    rst = 1'b0;
    tick(40);
    chk("rstmid_no_rsp", 32'(n_rsp[0] - r0), 32'd0);
    chk("rstmid_no_reload", 32'(ldq0.size()), 32'd1);
    send(0, 1'b1, 13'h001, 8'h00);
    wait_rsp(0, r0);
    tick(3);
    chk("rstmid_after_rdata", 32'(r_rdata[0]), 32'h0C);
    chk("rstmid_after_err", 32'(r_err[0]), 32'd0);
    chk("rstmid_after_nrsp", 32'(n_rsp[0] - r0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
